// File: rtl/ar_tag_slice.sv
// AR request slice: tags each accepted read-address request with the lowest free
// tag from a busy bitmap, and buffers it in an output register backed by one skid register.
module ar_tag_slice #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int TAG_WIDTH  = 4,
  parameter int NUM_TAGS   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // upstream request, untagged
  input  logic                  s_valid,
  input  logic [ID_WIDTH-1:0]   s_id,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [LEN_WIDTH-1:0]  s_len,
  input  logic [2:0]            s_size,
  input  logic [1:0]            s_burst,
  input  logic [3:0]            s_qos,
  output logic                  s_ready,
  // downstream request, tagged
  output logic                  m_valid,
  output logic [ID_WIDTH-1:0]   m_id,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [LEN_WIDTH-1:0]  m_len,
  output logic [2:0]            m_size,
  output logic [1:0]            m_burst,
  output logic [3:0]            m_qos,
  output logic [TAG_WIDTH-1:0]  m_tagid,
  input  logic                  m_ready,
  // tag retirement
  input  logic                  rel_valid,
  input  logic [TAG_WIDTH-1:0]  rel_tag,
  // status
  output logic [TAG_WIDTH:0]    free_cnt,
  output logic                  rel_err
);

  localparam logic [TAG_WIDTH:0] CNT_INIT = (TAG_WIDTH+1)'(NUM_TAGS);
  localparam logic [TAG_WIDTH:0] CNT_ONE  = (TAG_WIDTH+1)'(1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            qos;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  req_t                  out_q, out_d;
  req_t                  skid_q, skid_d;
  req_t                  new_req;
  logic                  out_valid_q, out_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [NUM_TAGS-1:0]   busy_q, busy_d;
  logic [TAG_WIDTH:0]    free_cnt_q, free_cnt_d;
  logic                  rel_err_q, rel_err_d;
  logic                  live_q;

  logic [TAG_WIDTH-1:0]  alloc_tag;
  logic                  rel_hit;
  logic                  rel_ok;
  logic                  accept;
  logic                  pop;

  // live_q keeps s_ready low during reset and rises on the first edge after it.
  assign s_ready = live_q && !skid_valid_q && (free_cnt_q != '0);
  assign accept  = s_valid && s_ready;
  assign pop     = out_valid_q && m_ready;

  // Lowest-index free tag; only used when free_cnt != 0, so one always exists.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tag = TAG_WIDTH'(i);
    end
  end

  // A release is legal only for an in-range tag that is currently busy.
  always_comb begin
    rel_hit = 1'b0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (rel_tag == TAG_WIDTH'(i)) rel_hit = busy_q[i];
    end
  end

  assign rel_ok = rel_valid && rel_hit;

  always_comb begin
    new_req.id    = s_id;
    new_req.addr  = s_addr;
    new_req.len   = s_len;
    new_req.size  = s_size;
    new_req.burst = s_burst;
    new_req.qos   = s_qos;
    new_req.tag   = alloc_tag;
  end

  // Bitmap, counter and sticky error; allocation sees the pre-release bitmap.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (accept && alloc_tag == TAG_WIDTH'(i)) busy_d[i] = 1'b1;
      if (rel_ok && rel_tag == TAG_WIDTH'(i))   busy_d[i] = 1'b0;
    end

    unique case ({accept, rel_ok})
      2'b10:   free_cnt_d = free_cnt_q - CNT_ONE;
      2'b01:   free_cnt_d = free_cnt_q + CNT_ONE;
      default: free_cnt_d = free_cnt_q;
    endcase

    rel_err_d = rel_err_q || (rel_valid && !rel_hit);
  end

  // Buffer steering. A full skid forces s_ready low, so a skid refill and
  // an accept never happen in the same cycle.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (pop && skid_valid_q) begin
      out_d        = skid_q;
      out_valid_d  = 1'b1;
      skid_valid_d = 1'b0;
    end else if (accept && (!out_valid_q || pop)) begin
      out_d       = new_req;
      out_valid_d = 1'b1;
    end else if (accept) begin
      skid_d       = new_req;
      skid_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset as well, because m_* must read zero during reset.
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      busy_q       <= '0;
      free_cnt_q   <= CNT_INIT;
      rel_err_q    <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all update together at the edge.
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      busy_q       <= busy_d;
      free_cnt_q   <= free_cnt_d;
      rel_err_q    <= rel_err_d;
      live_q       <= 1'b1;
    end
  end

  assign m_valid  = out_valid_q;
  assign m_id     = out_q.id;
  assign m_addr   = out_q.addr;
  assign m_len    = out_q.len;
  assign m_size   = out_q.size;
  assign m_burst  = out_q.burst;
  assign m_qos    = out_q.qos;
  assign m_tagid  = out_q.tag;
  assign free_cnt = free_cnt_q;
  assign rel_err  = rel_err_q;

endmodule

// File: tb/tb_ar_tag_slice.sv
// Directed bench for ar_tag_slice: a 16-tag instance for most cases and a
// 4-tag instance for pool exhaustion, both driven from shared request inputs.
module tb_ar_tag_slice;

  logic        clk = 1'b0;
  logic        rst_n, rst4_n;
  logic        s_valid;
  logic [3:0]  s_id;
  logic [31:0] s_addr;
  logic [7:0]  s_len;
  logic [2:0]  s_size;
  logic [1:0]  s_burst;
  logic [3:0]  s_qos;
  logic        m_ready;
  logic        rel_valid;
  logic [3:0]  rel_tag;

  logic        s_ready, m_valid, rel_err;
  logic [3:0]  m_id, m_qos, m_tagid;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  logic [4:0]  free_cnt;

  logic        s_ready4, m_valid4, rel_err4;
  logic [3:0]  m_id4, m_qos4, m_tagid4;
  logic [31:0] m_addr4;
  logic [7:0]  m_len4;
  logic [2:0]  m_size4;
  logic [1:0]  m_burst4;
  logic [4:0]  free_cnt4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ar_tag_slice dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_id(s_id), .s_addr(s_addr), .s_len(s_len),
    .s_size(s_size), .s_burst(s_burst), .s_qos(s_qos), .s_ready(s_ready),
    .m_valid(m_valid), .m_id(m_id), .m_addr(m_addr), .m_len(m_len),
    .m_size(m_size), .m_burst(m_burst), .m_qos(m_qos), .m_tagid(m_tagid),
    .m_ready(m_ready), .rel_valid(rel_valid), .rel_tag(rel_tag),
    .free_cnt(free_cnt), .rel_err(rel_err)
  );

  ar_tag_slice #(.NUM_TAGS(4)) dut4 (
    .clk(clk), .rst_n(rst4_n),
    .s_valid(s_valid), .s_id(s_id), .s_addr(s_addr), .s_len(s_len),
    .s_size(s_size), .s_burst(s_burst), .s_qos(s_qos), .s_ready(s_ready4),
    .m_valid(m_valid4), .m_id(m_id4), .m_addr(m_addr4), .m_len(m_len4),
    .m_size(m_size4), .m_burst(m_burst4), .m_qos(m_qos4), .m_tagid(m_tagid4),
    .m_ready(m_ready), .rel_valid(rel_valid), .rel_tag(rel_tag),
    .free_cnt(free_cnt4), .rel_err(rel_err4)
  );

  typedef struct {
    logic        sv;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic        mr;
    logic        rv;
    logic [3:0]  rt;
    logic        e_s_ready;
    logic        e_m_valid;
    logic [3:0]  e_id;
    logic [31:0] e_addr;
    logic [7:0]  e_len;
    logic [3:0]  e_tag;
    logic [4:0]  e_free;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [3:0] id, input logic [31:0] addr,
                       input logic [7:0] len, input logic mr, input logic rv,
                       input logic [3:0] rt);
    s_valid   = sv;
    s_id      = id;
    s_addr    = addr;
    s_len     = len;
    s_size    = 3'd2;
    s_burst   = 2'd1;
    s_qos     = id;
    m_ready   = mr;
    rel_valid = rv;
    rel_tag   = rt;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst4_n = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 8'd0, 1'b0, 1'b0, 4'd0);

    // Stream with m_ready high; row 2 allocates while tag 0 is released.
    vecs[0] = '{1'b1, 4'd3, 32'h1000, 8'd7,   1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 32'h1000, 8'd7,   4'd0, 5'd15};
    vecs[1] = '{1'b1, 4'd5, 32'h2000, 8'd1,   1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 32'h2000, 8'd1,   4'd1, 5'd14};
    vecs[2] = '{1'b1, 4'd6, 32'h3000, 8'd0,   1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 4'd6, 32'h3000, 8'd0,   4'd2, 5'd14};
    vecs[3] = '{1'b1, 4'd7, 32'h4000, 8'hff,  1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd7, 32'h4000, 8'hff,  4'd0, 5'd13};
    vecs[4] = '{1'b0, 4'd0, 32'h0,    8'd0,   1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 32'h0,    8'd0,   4'd0, 5'd14};
    vecs[5] = '{1'b0, 4'd0, 32'h0,    8'd0,   1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 32'h0,    8'd0,   4'd0, 5'd15};
    vecs[6] = '{1'b0, 4'd0, 32'h0,    8'd0,   1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0,    8'd0,   4'd0, 5'd16};

    // Reset state
    #12;
    check("rst_m_valid", m_valid, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_free_cnt", free_cnt, 16);
    check("rst_rel_err", rel_err, 0);
    check("rst_m_id", m_id, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_tagid", m_tagid, 0);
    check("rst4_free_cnt", free_cnt4, 4);
    rst_n = 1'b1;
    #1;
    check("s_ready_low_before_edge", s_ready, 0);
    tick();
    check("s_ready_after_first_edge", s_ready, 1);

    // Table-driven stream
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].sv, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].mr, vecs[i].rv, vecs[i].rt);
      tick();
      check($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].e_s_ready);
      check($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].e_m_valid);
      check($sformatf("vec%0d_free_cnt", i), free_cnt, vecs[i].e_free);
      if (vecs[i].e_m_valid) begin
        check($sformatf("vec%0d_m_id", i), m_id, vecs[i].e_id);
        check($sformatf("vec%0d_m_addr", i), m_addr, vecs[i].e_addr);
        check($sformatf("vec%0d_m_len", i), m_len, vecs[i].e_len);
        check($sformatf("vec%0d_m_tagid", i), m_tagid, vecs[i].e_tag);
        check($sformatf("vec%0d_m_qos", i), m_qos, vecs[i].e_id);
        check($sformatf("vec%0d_m_size", i), m_size, 3'd2);
        check($sformatf("vec%0d_m_burst", i), m_burst, 2'd1);
      end
    end

    // Backpressure: two accepted, third waits, then in-order drain.
    drive(1'b1, 4'd1, 32'hA000, 8'd3, 1'b0, 1'b0, 4'd0);
    tick();
    check("bp1_m_tagid", m_tagid, 0);
    check("bp1_s_ready", s_ready, 1);
    drive(1'b1, 4'd2, 32'hB000, 8'd3, 1'b0, 1'b0, 4'd0);
    tick();
    check("bp2_s_ready", s_ready, 0);
    check("bp2_m_id_held", m_id, 1);
    check("bp2_free_cnt", free_cnt, 14);
    drive(1'b1, 4'd3, 32'hC000, 8'd3, 1'b0, 1'b0, 4'd0);
    tick();
    check("bp3_s_ready", s_ready, 0);
    check("bp3_m_addr_held", m_addr, 32'hA000);
    check("bp3_m_tagid_held", m_tagid, 0);
    check("bp3_free_cnt", free_cnt, 14);
    m_ready = 1'b1;
    tick();
    check("bp4_m_id", m_id, 2);
    check("bp4_m_tagid", m_tagid, 1);
    check("bp4_s_ready", s_ready, 1);
    check("bp4_free_cnt", free_cnt, 14);
    tick();
    check("bp5_m_id", m_id, 3);
    check("bp5_m_tagid", m_tagid, 2);
    check("bp5_free_cnt", free_cnt, 13);
    s_valid = 1'b0;
    tick();
    check("bp6_m_valid", m_valid, 0);
    for (int t = 0; t < 3; t++) begin
      drive(1'b0, 4'd0, 32'd0, 8'd0, 1'b1, 1'b1, 4'(t));
      tick();
    end
    check("bp_released_free_cnt", free_cnt, 16);
    check("bp_rel_err_clear", rel_err, 0);

    // Illegal release of a free tag
    drive(1'b0, 4'd0, 32'd0, 8'd0, 1'b1, 1'b1, 4'd5);
    tick();
    check("illegal_rel_err", rel_err, 1);
    check("illegal_free_cnt", free_cnt, 16);
    rel_valid = 1'b0;
    tick();
    check("illegal_rel_err_sticky", rel_err, 1);
    check("illegal_free_cnt_2", free_cnt, 16);

    // Same-cycle alloc and release while tags 0..2 are busy
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 4'(8 + k), 32'h100 * (k + 1), 8'd0, 1'b1, 1'b0, 4'd0);
      tick();
    end
    check("pre_same_m_tagid", m_tagid, 2);
    check("pre_same_free_cnt", free_cnt, 13);
    drive(1'b1, 4'd11, 32'h5000, 8'd2, 1'b1, 1'b1, 4'd0);
    tick();
    check("same_m_tagid", m_tagid, 3);
    check("same_free_cnt", free_cnt, 13);
    drive(1'b1, 4'd12, 32'h6000, 8'd2, 1'b1, 1'b0, 4'd0);
    tick();
    check("after_same_m_tagid", m_tagid, 0);
    check("after_same_free_cnt", free_cnt, 12);

    // Asynchronous reset with two entries buffered
    drive(1'b1, 4'd13, 32'h7000, 8'd2, 1'b0, 1'b0, 4'd0);
    tick();
    check("pre_rst_s_ready", s_ready, 0);
    check("pre_rst_m_id", m_id, 12);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", m_valid, 0);
    check("async_rst_free_cnt", free_cnt, 16);
    check("async_rst_s_ready", s_ready, 0);
    check("async_rst_rel_err", rel_err, 0);
    check("async_rst_m_tagid", m_tagid, 0);
    s_valid = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    check("post_rst_s_ready_pre_edge", s_ready, 0);
    tick();
    check("post_rst_s_ready", s_ready, 1);
    check("post_rst_m_valid", m_valid, 0);
    drive(1'b0, 4'd0, 32'd0, 8'd0, 1'b1, 1'b1, 4'd0);
    tick();
    check("stale_rel_err", rel_err, 1);
    check("stale_free_cnt", free_cnt, 16);
    rel_valid = 1'b0;

    // Pool exhaustion on the 4-tag instance
    rst4_n = 1'b1;
    tick();
    check("p4_s_ready", s_ready4, 1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'(k + 1), 32'h10 * k, 8'd0, 1'b1, 1'b0, 4'd0);
      tick();
      check($sformatf("p4_alloc%0d_tag", k), m_tagid4, 4'(k));
      check($sformatf("p4_alloc%0d_free", k), free_cnt4, 5'(3 - k));
    end
    check("p4_empty_s_ready", s_ready4, 0);
    drive(1'b1, 4'd5, 32'h900, 8'd1, 1'b1, 1'b1, 4'd2);
    tick();
    check("p4_rel_free", free_cnt4, 1);
    check("p4_rel_s_ready", s_ready4, 1);
    check("p4_rel_m_valid", m_valid4, 0);
    rel_valid = 1'b0;
    tick();
    check("p4_realloc_m_valid", m_valid4, 1);
    check("p4_realloc_tag", m_tagid4, 2);
    check("p4_realloc_id", m_id4, 5);
    check("p4_realloc_free", free_cnt4, 0);
    check("p4_rel_err", rel_err4, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ar_tag_slice.md
AR_TAG_SLICE -- requirements
Module: ar_tag_slice

Interface
REQ-001 SHALL have parameters: ID_WIDTH 4, AXI ID width; ADDR_WIDTH 32, address width; LEN_WIDTH 8, burst length width; TAG_WIDTH 4, internal tag width; NUM_TAGS 16, tag pool size, legal range 1..2^TAG_WIDTH.
REQ-002 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: s_valid  in  1; s_id  in  ID_WIDTH; s_addr  in  ADDR_WIDTH; s_len  in  LEN_WIDTH; s_size  in  3; s_burst  in  2; s_qos  in  4; s_ready  out  1. Together these form the upstream AR request, which carries no tag.
REQ-004 SHALL have ports: m_valid  out  1; m_id, m_addr, m_len, m_size, m_burst, m_qos  out, same widths as the s_ fields; m_tagid  out  TAG_WIDTH; m_ready  in  1. Together these form the downstream AR request with its allocated tag.
REQ-005 SHALL have ports: rel_valid  in  1, tag release strobe; rel_tag  in  TAG_WIDTH, tag being retired.
REQ-006 SHALL have ports: free_cnt  out  TAG_WIDTH+1, number of free tags; rel_err  out  1, sticky illegal-release flag.

Function
REQ-007 SHALL keep a NUM_TAGS-bit busy bitmap; bit i set = tag i in flight.
REQ-008 SHALL buffer requests in two registers: an output register driving m_*, and one skid register.
REQ-009 SHALL drive s_ready = !skid_full && (free_cnt != 0), decoded from registers only; no combinational path from m_ready or s_valid.
REQ-010 SHALL treat a cycle with s_valid && s_ready as an upstream accept. On accept the block allocates the lowest-index free tag, based on the bitmap at the start of the cycle, and sets its busy bit at the clock edge.
REQ-011 SHALL load an accepted request into the output register when that register is empty or is being popped (m_ready high) this cycle; otherwise into the skid register.
REQ-012 SHALL present a request on m_valid one cycle after it is accepted into an empty slice; there is no combinational bypass from s_* to m_*.
REQ-013 SHALL move the skid entry into the output register on a downstream pop (m_valid && m_ready) while the skid register is full. That cycle s_ready is low, so no new request is accepted.
REQ-014 SHALL hold every m_* field stable while m_valid && !m_ready.
REQ-015 SHALL sustain full throughput: one request per cycle with m_ready held high and tags available.
REQ-016 SHALL clear busy[rel_tag] at the clock edge when rel_valid is high, rel_tag < NUM_TAGS and busy[rel_tag] is set.
REQ-017 SHALL ignore a release of an already-free tag or of rel_tag >= NUM_TAGS, leaving the bitmap unchanged, and SHALL set rel_err, which stays set until reset.
REQ-018 SHALL make a tag released in cycle N allocatable in cycle N+1 at the earliest. If allocation and release occur in the same cycle, the allocation uses the pre-release bitmap.
REQ-019 SHALL update free_cnt each cycle as free_cnt + releases - allocations, with a net change of +1, 0 or -1. Simultaneous alloc and release yields no change.
REQ-020 SHALL hold s_ready low while free_cnt == 0; an s_valid in this state waits and is not lost.
REQ-021 SHALL pass the AXI fields through unmodified; the block never alters id, addr, len, size, burst or qos.

Reset
REQ-022 SHALL, while rst_n is low, asynchronously clear the bitmap, both buffer registers, m_valid and rel_err; set free_cnt = NUM_TAGS; force s_ready low.
REQ-023 SHALL raise s_ready on the first rising clk edge after rst_n deasserts.
REQ-024 SHALL discard any buffered requests and allocated tags on reset mid-operation; releases arriving after reset for pre-reset tags set rel_err.
REQ-025 SHALL drive all m_* data fields and m_tagid to zero during reset.

Verification
REQ-026 Single request, m_ready=1: id=3, addr=0x1000, len=7 accepted at cycle 0 -> m_valid at cycle 1 with m_tagid=0, fields unchanged; free_cnt goes 16->15.
REQ-027 Backpressure: m_ready=0, three requests offered back-to-back -> first two accepted (tags 0,1), s_ready low on third. With m_ready=1 the slice drains in order 0,1, then accepts the third with tag 2.
REQ-028 Pool exhaustion with NUM_TAGS=4: four accepts -> free_cnt=0, s_ready=0. Release tag 2 -> the next accept occurs one cycle later with m_tagid=2.
REQ-029 Same-cycle alloc and release of tag 0 while tags 0..2 are busy -> the allocation gets tag 3, free_cnt is unchanged, tag 0 is free the following cycle.
REQ-030 Illegal release of free tag 5 -> bitmap and free_cnt unchanged, rel_err=1, which persists until rst_n low.
REQ-031 rst_n pulsed low asynchronously with two entries buffered -> m_valid=0 immediately, free_cnt=NUM_TAGS, s_ready=1 one edge after deassert.
